// File: rtl/stair_animator_if.sv
// Pixel write port from the stair animator to the VGA adapter.
// The animator drives the port through master; the adapter reads it through slave.
interface stair_animator_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (output x, y, colour, plot);
  modport slave  (input  x, y, colour, plot);
endinterface

// File: rtl/stair_animator.sv
// Multi-stair draw/erase engine for the VGA stair game.
// Scans every stair rectangle one pixel per cycle and paces moves from an internal frame counter.
module stair_animator #(
  parameter int unsigned NUM_STAIRS      = 4,
  parameter int unsigned STAIR_W         = 40,
  parameter int unsigned STAIR_H         = 5,
  parameter int unsigned FRAME_TICKS     = 833334,
  parameter int unsigned FRAMES_PER_MOVE = 4,
  parameter int unsigned STEP            = 1,
  parameter int unsigned Y_WRAP          = 116,
  parameter logic [2:0]  DRAW_COLOUR     = 3'b100,
  parameter logic [2:0]  BG_COLOUR       = 3'b000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    go,
  input  logic                    pause,
  input  logic [8*NUM_STAIRS-1:0] stair_x_in,
  input  logic [7*NUM_STAIRS-1:0] stair_y_in,
  stair_animator_if.master        vga,
  output logic                    busy,
  output logic                    moved,
  output logic [2:0]              current_state
);

  localparam int unsigned IW    = (NUM_STAIRS > 1) ? $clog2(NUM_STAIRS) : 1;
  localparam int unsigned SLOTS = 1 << IW;
  localparam int unsigned TW    = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned FW    = $clog2(FRAMES_PER_MOVE + 1);

  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_STAIRS - 1);
  localparam logic [7:0]    PX_LAST    = 8'(STAIR_W - 1);
  localparam logic [6:0]    PY_LAST    = 7'(STAIR_H - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(FRAME_TICKS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_MOVE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GO_WAIT = 3'd1,
    S_LOAD    = 3'd2,
    S_DRAW    = 3'd3,
    S_WAIT    = 3'd4,
    S_ERASE   = 3'd5,
    S_MOVE    = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      px_q, px_d;
  logic [6:0]      py_q, py_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [7:0]      pos_x_q [SLOTS];
  logic [7:0]      pos_x_d [SLOTS];
  logic [6:0]      pos_y_q [SLOTS];
  logic [6:0]      pos_y_d [SLOTS];
  logic [7:0]      x_q, x_d;
  logic [6:0]      y_q, y_d;
  logic [2:0]      colour_q, colour_d;
  logic            plot_q, plot_d;
  logic            busy_q, busy_d;
  logic            moved_q, moved_d;

  logic [8:0]      pix_x_sum;
  logic [7:0]      pix_y_sum;
  logic            scan_last;

  // Full-width sums so off-screen pixels can be detected before truncation.
  assign pix_x_sum = 9'(pos_x_q[idx_q]) + 9'(px_q);
  assign pix_y_sum = 8'(pos_y_q[idx_q]) + 8'(py_q);
  assign scan_last = (idx_q == IDX_LAST) && (px_q == PX_LAST) && (py_q == PY_LAST);

  always_comb begin
    state_d  = state_q;
    idx_d    = '0;
    px_d     = '0;
    py_d     = '0;
    tick_d   = '0;
    frame_d  = '0;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;

    case (state_q)
      S_IDLE:    if (go)  state_d = S_GO_WAIT;
      S_GO_WAIT: if (!go) state_d = S_LOAD;
      S_LOAD: begin
        for (int unsigned k = 0; k < NUM_STAIRS; k++) begin
          pos_x_d[IW'(k)] = stair_x_in[8*k +: 8];
          pos_y_d[IW'(k)] = stair_y_in[7*k +: 7];
        end
        state_d = S_DRAW;
      end
      S_DRAW, S_ERASE: begin
        x_d      = pix_x_sum[7:0];
        y_d      = pix_y_sum[6:0];
        colour_d = (state_q == S_DRAW) ? DRAW_COLOUR : BG_COLOUR;
        plot_d   = (pix_x_sum <= 9'd159) && (pix_y_sum <= 8'd119);
        // px is the inner loop, py the outer, stair index outermost.
        idx_d = idx_q;
        px_d  = px_q + 8'd1;
        py_d  = py_q;
        if (px_q == PX_LAST) begin
          px_d = '0;
          py_d = py_q + 7'd1;
          if (py_q == PY_LAST) begin
            py_d  = '0;
            idx_d = idx_q + IW'(1);
          end
        end
        if (scan_last) begin
          idx_d   = '0;
          state_d = (state_q == S_DRAW) ? S_WAIT : S_MOVE;
        end
      end
      S_WAIT: begin
        tick_d  = tick_q;
        frame_d = frame_q;
        if (!pause) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            frame_d = frame_q + FW'(1);
            if (frame_q == FRAME_LAST) state_d = S_ERASE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_MOVE: begin
        for (int unsigned k = 0; k < NUM_STAIRS; k++) begin
          if (pos_y_q[IW'(k)] >= 7'(STEP)) pos_y_d[IW'(k)] = pos_y_q[IW'(k)] - 7'(STEP);
          else                             pos_y_d[IW'(k)] = 7'(Y_WRAP);
        end
        state_d = S_DRAW;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_LOAD) || (state_d == S_DRAW) ||
              (state_d == S_ERASE) || (state_d == S_MOVE);
    moved_d = (state_d == S_MOVE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      px_q     <= '0;
      py_q     <= '0;
      tick_q   <= '0;
      frame_q  <= '0;
      pos_x_q  <= '{default: '0};
      pos_y_q  <= '{default: '0};
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      moved_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      px_q     <= px_d;
      py_q     <= py_d;
      tick_q   <= tick_d;
      frame_q  <= frame_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      moved_q  <= moved_d;
    end
  end

  assign vga.x         = x_q;
  assign vga.y         = y_q;
  assign vga.colour    = colour_q;
  assign vga.plot      = plot_q;
  assign busy          = busy_q;
  assign moved         = moved_q;
  assign current_state = state_q;

endmodule

// File: tb/tb_stair_animator.sv
// Bench for stair_animator: scripted scenarios plus randomized positions and pause patterns,
// each pass compared against a rectangle-scan reference model.
module tb_stair_animator;

  localparam int NS = 2, W = 4, H = 2, FT = 3, FPM = 2, STEP = 1, YW = 116;
  localparam int PASS_LEN = NS * W * H;
  localparam int WAIT_LEN = FT * FPM;
  localparam logic [2:0] DRAW_C = 3'b100, BG_C = 3'b000;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            go    = 1'b0;
  logic            pause = 1'b0;
  logic [8*NS-1:0] stair_x_in = '0;
  logic [7*NS-1:0] stair_y_in = '0;
  logic            busy, moved;
  logic [2:0]      current_state;

  stair_animator_if vga_if ();

  stair_animator #(
    .NUM_STAIRS(NS), .STAIR_W(W), .STAIR_H(H), .FRAME_TICKS(FT),
    .FRAMES_PER_MOVE(FPM), .STEP(STEP), .Y_WRAP(YW),
    .DRAW_COLOUR(DRAW_C), .BG_COLOUR(BG_C)
  ) dut (
    .clock(clock), .reset(reset), .go(go), .pause(pause),
    .stair_x_in(stair_x_in), .stair_y_in(stair_y_in),
    .vga(vga_if), .busy(busy), .moved(moved), .current_state(current_state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: current stair positions as plain integers.
  int mx[NS];
  int my[NS];

  logic [7:0] cap_x[$];
  logic [6:0] cap_y[$];
  logic [2:0] cap_c[$];
  logic       cap_p[$];
  int         cap_len;

  task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
    int g = 0;
    while (current_state !== st && g < budget) begin
      @(negedge clock);
      g++;
    end
    ok = (current_state === st);
  endtask

  // Records one scan pass; pixel outputs trail the scan state by one cycle.
  task automatic capture_pass(input logic [2:0] st);
    bit ok;
    cap_x.delete(); cap_y.delete(); cap_c.delete(); cap_p.delete();
    cap_len = 0;
    wait_state(st, 200, ok);
    if (!ok) return;
    while (current_state === st && cap_len < 1000) begin
      cap_len++;
      @(negedge clock);
      cap_x.push_back(vga_if.x);
      cap_y.push_back(vga_if.y);
      cap_c.push_back(vga_if.colour);
      cap_p.push_back(vga_if.plot);
    end
  endtask

  function automatic int pass_errors(input logic [2:0] col);
    int k = 0;
    int e = 0;
    for (int i = 0; i < NS; i++)
      for (int py = 0; py < H; py++)
        for (int px = 0; px < W; px++) begin
          int   sx = mx[i] + px;
          int   sy = my[i] + py;
          logic ep = (sx <= 159) && (sy <= 119);
          if (k >= cap_x.size()) e++;
          else if (cap_p[k] !== ep || cap_x[k] !== 8'(sx) || cap_y[k] !== 7'(sy) || cap_c[k] !== col) begin
            e++;
            $display("  pixel %0d: got x=%0d y=%0d c=%0d p=%0d, want x=%0d y=%0d c=%0d p=%0d",
                     k, cap_x[k], cap_y[k], cap_c[k], cap_p[k], 8'(sx), 7'(sy), col, ep);
          end
          k++;
        end
    return e;
  endfunction

  function automatic int plot_count(input int from, input int to);
    int c = 0;
    for (int k = from; k < to && k < cap_p.size(); k++) if (cap_p[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic void model_move();
    for (int i = 0; i < NS; i++) my[i] = (my[i] >= STEP) ? my[i] - STEP : YW;
  endfunction

  task automatic load_inputs();
    for (int i = 0; i < NS; i++) begin
      stair_x_in[8*i +: 8] = 8'(mx[i]);
      stair_y_in[7*i +: 7] = 7'(my[i]);
    end
  endtask

  task automatic do_start();
    bit ok;
    reset = 1'b1; go = 1'b0; pause = 1'b0;
    load_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    go = 1'b1;
    repeat (3) @(negedge clock);
    go = 1'b0;
    wait_state(3'd3, 20, ok);
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (current_state !== 3'd0) $display("FAIL reset_state got %0d want 0", current_state); else n_pass++;
    n_checks++; if (vga_if.plot !== 1'b0) $display("FAIL reset_plot got %0b want 0", vga_if.plot); else n_pass++;
    n_checks++; if ({vga_if.x, vga_if.y, vga_if.colour} !== 18'd0)
      $display("FAIL reset_pixel got x=%0d y=%0d c=%0d want 0/0/0", vga_if.x, vga_if.y, vga_if.colour); else n_pass++;
    n_checks++; if ({busy, moved} !== 2'b00) $display("FAIL reset_flags got busy=%0b moved=%0b want 0/0", busy, moved); else n_pass++;
  endtask

  task automatic test_start_draw();
    mx = '{10, 100}; my = '{20, 0};
    load_inputs();
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (current_state !== 3'd0) $display("FAIL start_idle got %0d want 0", current_state); else n_pass++;
    go = 1'b1;
    @(negedge clock);
    n_checks++; if (current_state !== 3'd1) $display("FAIL start_gowait got %0d want 1", current_state); else n_pass++;
    repeat (2) @(negedge clock);
    n_checks++; if (current_state !== 3'd1) $display("FAIL start_gowait_hold got %0d want 1", current_state); else n_pass++;
    go = 1'b0;
    @(negedge clock);
    n_checks++; if (current_state !== 3'd2 || busy !== 1'b1)
      $display("FAIL start_load got state=%0d busy=%0b want 2/1", current_state, busy); else n_pass++;
    @(negedge clock);
    n_checks++; if (current_state !== 3'd3 || vga_if.plot !== 1'b0)
      $display("FAIL start_draw_entry got state=%0d plot=%0b want 3/0", current_state, vga_if.plot); else n_pass++;
    capture_pass(3'd3);
    n_checks++; if (cap_len !== PASS_LEN) $display("FAIL draw_len got %0d want %0d", cap_len, PASS_LEN); else n_pass++;
    n_checks++; if (cap_x.size() == 0 || cap_x[0] !== 8'd10 || cap_y[0] !== 7'd20 || cap_c[0] !== 3'b100 || cap_p[0] !== 1'b1)
      $display("FAIL draw_first_pixel got x=%0d y=%0d c=%0d want 10/20/4", cap_x[0], cap_y[0], cap_c[0]); else n_pass++;
    n_checks++; if (plot_count(0, PASS_LEN) !== 16) $display("FAIL draw_plot_count got %0d want 16", plot_count(0, PASS_LEN)); else n_pass++;
    n_checks++; if (cap_x.size() != 16 || cap_x[15] !== 8'd103 || cap_y[15] !== 7'd1 || cap_p[15] !== 1'b1)
      $display("FAIL draw_last_pixel got size=%0d want x=103 y=1 plot=1", cap_x.size()); else n_pass++;
    n_checks++; if (pass_errors(DRAW_C) !== 0) $display("FAIL draw_pixels got %0d bad pixels want 0", pass_errors(DRAW_C)); else n_pass++;
    n_checks++; if (current_state !== 3'd4) $display("FAIL draw_to_wait got %0d want 4", current_state); else n_pass++;
  endtask

  task automatic test_wait_erase_move();
    int n = 0;
    int bad = 0;
    while (current_state === 3'd4 && n < 100) begin
      n++;
      @(negedge clock);
      if (current_state === 3'd4 && vga_if.plot !== 1'b0) bad++;
    end
    n_checks++; if (n !== WAIT_LEN) $display("FAIL wait_len got %0d want %0d", n, WAIT_LEN); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL wait_no_plot got %0d plots want 0", bad); else n_pass++;
    capture_pass(3'd5);
    n_checks++; if (cap_len !== PASS_LEN) $display("FAIL erase_len got %0d want %0d", cap_len, PASS_LEN); else n_pass++;
    n_checks++; if (pass_errors(BG_C) !== 0) $display("FAIL erase_pixels got %0d bad want 0", pass_errors(BG_C)); else n_pass++;
    n_checks++; if (current_state !== 3'd6 || moved !== 1'b1 || busy !== 1'b1)
      $display("FAIL move_state got state=%0d moved=%0b busy=%0b want 6/1/1", current_state, moved, busy); else n_pass++;
    model_move();
    @(negedge clock);
    n_checks++; if (current_state !== 3'd3 || moved !== 1'b0)
      $display("FAIL move_to_draw got state=%0d moved=%0b want 3/0", current_state, moved); else n_pass++;
    capture_pass(3'd3);
    n_checks++; if (pass_errors(DRAW_C) !== 0) $display("FAIL redraw_pixels got %0d bad want 0", pass_errors(DRAW_C)); else n_pass++;
    n_checks++; if (cap_x.size() < 9 || cap_x[0] !== 8'd10 || cap_y[0] !== 7'd19 || cap_x[8] !== 8'd100 || cap_y[8] !== 7'd116)
      $display("FAIL redraw_positions got (%0d,%0d),(%0d,%0d) want (10,19),(100,116)", cap_x[0], cap_y[0], cap_x[8], cap_y[8]); else n_pass++;
  endtask

  task automatic test_pause();
    int n = 0;
    int bad = 0;
    while (current_state === 3'd4 && n < 200) begin
      pause = (n >= 2 && n < 22);
      n++;
      @(negedge clock);
      if (pause && (current_state !== 3'd4 || vga_if.plot !== 1'b0)) bad++;
    end
    pause = 1'b0;
    n_checks++; if (bad !== 0) $display("FAIL pause_hold got %0d disturbed cycles want 0", bad); else n_pass++;
    n_checks++; if (n !== WAIT_LEN + 20) $display("FAIL pause_wait_len got %0d want %0d", n, WAIT_LEN + 20); else n_pass++;
    n_checks++; if (current_state !== 3'd5) $display("FAIL pause_to_erase got %0d want 5", current_state); else n_pass++;
  endtask

  task automatic test_clipping();
    mx = '{10, 158}; my = '{20, 119};
    do_start();
    capture_pass(3'd3);
    n_checks++; if (cap_len !== PASS_LEN) $display("FAIL clip_len got %0d want %0d", cap_len, PASS_LEN); else n_pass++;
    n_checks++; if (plot_count(8, 16) !== 2) $display("FAIL clip_plots got %0d want 2", plot_count(8, 16)); else n_pass++;
    n_checks++; if (cap_p.size() < 10 || cap_p[8] !== 1'b1 || cap_p[9] !== 1'b1 || cap_x[9] !== 8'd159 || cap_y[9] !== 7'd119)
      $display("FAIL clip_visible got size=%0d want (158,119),(159,119) plotted", cap_p.size()); else n_pass++;
    n_checks++; if (pass_errors(DRAW_C) !== 0) $display("FAIL clip_pixels got %0d bad want 0", pass_errors(DRAW_C)); else n_pass++;
  endtask

  task automatic test_reset_mid_draw();
    mx = '{10, 100}; my = '{20, 0};
    do_start();
    repeat (4) @(negedge clock);
    n_checks++; if (current_state !== 3'd3) $display("FAIL midreset_pre got %0d want 3", current_state); else n_pass++;
    reset = 1'b1; go = 1'b1;
    @(negedge clock);
    n_checks++; if (current_state !== 3'd0 || vga_if.plot !== 1'b0 || busy !== 1'b0)
      $display("FAIL midreset_state got state=%0d plot=%0b busy=%0b want 0/0/0", current_state, vga_if.plot, busy); else n_pass++;
    n_checks++; if ({vga_if.x, vga_if.y, vga_if.colour} !== 18'd0)
      $display("FAIL midreset_pixel got x=%0d y=%0d c=%0d want 0/0/0", vga_if.x, vga_if.y, vga_if.colour); else n_pass++;
    @(negedge clock);
    reset = 1'b0; go = 1'b0;
    @(negedge clock);
    n_checks++; if (current_state !== 3'd0) $display("FAIL midreset_go_ignored got %0d want 0", current_state); else n_pass++;
  endtask

  task automatic test_go_ignored();
    int n = 0;
    mx = '{10, 100}; my = '{20, 0};
    do_start();
    go = 1'b1;
    capture_pass(3'd3);
    n_checks++; if (cap_len !== PASS_LEN || pass_errors(DRAW_C) !== 0)
      $display("FAIL go_draw got len=%0d want %0d with clean pixels", cap_len, PASS_LEN); else n_pass++;
    while (current_state === 3'd4 && n < 100) begin
      n++;
      @(negedge clock);
    end
    n_checks++; if (n !== WAIT_LEN) $display("FAIL go_wait_len got %0d want %0d", n, WAIT_LEN); else n_pass++;
    capture_pass(3'd5);
    n_checks++; if (cap_len !== PASS_LEN || current_state !== 3'd6)
      $display("FAIL go_erase got len=%0d state=%0d want %0d/6", cap_len, current_state, PASS_LEN); else n_pass++;
    go = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int n = 0;
      int p = 0;
      for (int i = 0; i < NS; i++) begin
        mx[i] = int'($urandom_range(0, 255));
        my[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 127));
      end
      do_start();
      capture_pass(3'd3);
      n_checks++; if (cap_len !== PASS_LEN || pass_errors(DRAW_C) !== 0)
        $display("FAIL rand_draw it=%0d got len=%0d want %0d with clean pixels", it, cap_len, PASS_LEN); else n_pass++;
      while (current_state === 3'd4 && n < 200) begin
        pause = ($urandom_range(0, 1) == 1);
        if (pause) p++;
        n++;
        @(negedge clock);
      end
      pause = 1'b0;
      n_checks++; if (n !== WAIT_LEN + p) $display("FAIL rand_wait it=%0d got %0d want %0d", it, n, WAIT_LEN + p); else n_pass++;
      capture_pass(3'd5);
      n_checks++; if (pass_errors(BG_C) !== 0 || moved !== 1'b1)
        $display("FAIL rand_erase it=%0d got moved=%0b want clean erase and moved=1", it, moved); else n_pass++;
      model_move();
      capture_pass(3'd3);
      n_checks++; if (cap_len !== PASS_LEN || pass_errors(DRAW_C) !== 0)
        $display("FAIL rand_redraw it=%0d got len=%0d want %0d with clean pixels", it, cap_len, PASS_LEN); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_start_draw();
    test_wait_erase_move();
    test_pause();
    test_clipping();
    test_reset_mid_draw();
    test_go_ignored();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
